matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer_pkg.sv | 23 ++
 rtl/matmul_sequencer_skew_lane_gen.sv | 28 ++
 rtl/matmul_sequencer.sv | 156 +++++++++++++++
 tb/tb_matmul_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sequencer_pkg.sv
// Shared types and constants for the systolic-array matmul sequencer.
package matmul_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int ARRAY_DIM_DEF = 4;
  localparam int IDX_W_DEF     = 2;

  // The last PE (N-1,N-1) sees its final operand pair 3N-3 cycles after the
  // first operand enters the array, so a pass needs 3N-2 compute cycles.
  function automatic int run_len(input int n);
    return 3 * n - 2;
  endfunction

  localparam int RUN_LEN_DEF = 3 * ARRAY_DIM_DEF - 2;

endpackage

// File: rtl/matmul_sequencer_skew_lane_gen.sv
// Skew decode: turns the RUN cycle count t into per-lane read strobes and
// element indices. Lane k is live for t in [k, k+N-1] and reads element t-k.
module skew_lane_gen
  import matmul_sequencer_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int T_W       = 4
) (
  input  logic                       run_i,
  input  logic [T_W-1:0]             t_i,
  output logic [ARRAY_DIM-1:0]       lane_en_o,
  output logic [ARRAY_DIM*IDX_W-1:0] lane_elem_o
);

  // Per-lane window decode; everything stays zero outside RUN.
  always_comb begin
    lane_en_o   = '0;
    lane_elem_o = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      if (run_i && (int'(t_i) >= i) && (int'(t_i) < i + ARRAY_DIM)) begin
        lane_en_o[i]                  = 1'b1;
        lane_elem_o[i*IDX_W +: IDX_W] = IDX_W'(int'(t_i) - i);
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Matmul pass sequencer: clear accumulators, stream skewed operands through
// the systolic array, then walk the result selects row-major.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_CLEAR | one cycle of array_clear
//   ST_RUN   | 3N-2 compute cycles, t counts 0..3N-3, skewed A/B reads
//   ST_READ  | present result (row,col); advance on result_ready
//   ST_DONE  | one-cycle done pulse, then back to idle
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       result_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       array_clear,
  output logic                       array_compute_enable,
  output logic [ARRAY_DIM-1:0]       mema_read_enable,
  output logic [ARRAY_DIM*IDX_W-1:0] mema_read_elem,
  output logic [ARRAY_DIM-1:0]       memb_read_enable,
  output logic [ARRAY_DIM*IDX_W-1:0] memb_read_elem,
  output logic [IDX_W-1:0]           array_output_row,
  output logic [IDX_W-1:0]           array_output_column,
  output logic                       result_valid
);

  localparam int RUN_LEN = run_len(ARRAY_DIM);
  localparam int T_W     = $clog2(RUN_LEN);

  localparam logic [T_W-1:0]   T_LAST   = T_W'(RUN_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARRAY_DIM - 1);

  state_e           state_q, state_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             run_active;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next-state and counter update; abort overrides everything at the end.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    row_d   = row_q;
    col_d   = col_q;

    unique case (state_q)
      ST_IDLE: begin
        t_d   = '0;
        row_d = '0;
        col_d = '0;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        t_d     = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (t_q == T_LAST) begin
          t_d     = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_READ;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_READ: begin
        if (result_ready) begin
          if (row_q == IDX_LAST && col_q == IDX_LAST) begin
            row_d   = '0;
            col_d   = '0;
            state_d = ST_DONE;
          end else if (col_q == IDX_LAST) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
        row_d   = '0;
        col_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      t_d     = '0;
      row_d   = '0;
      col_d   = '0;
    end
  end

  // Outputs decode from registered state only, so no input reaches an output
  // within the same cycle. Selects are already zero outside READ.
  assign busy                 = (state_q != ST_IDLE);
  assign done                 = (state_q == ST_DONE);
  assign array_clear          = (state_q == ST_CLEAR);
  assign array_compute_enable = (state_q == ST_RUN);
  assign result_valid         = (state_q == ST_READ);
  assign array_output_row     = row_q;
  assign array_output_column  = col_q;
  assign run_active           = (state_q == ST_RUN);

  skew_lane_gen #(
    .ARRAY_DIM(ARRAY_DIM),
    .IDX_W    (IDX_W),
    .T_W      (T_W)
  ) u_skew_a (
    .run_i      (run_active),
    .t_i        (t_q),
    .lane_en_o  (mema_read_enable),
    .lane_elem_o(mema_read_elem)
  );

  skew_lane_gen #(
    .ARRAY_DIM(ARRAY_DIM),
    .IDX_W    (IDX_W),
    .T_W      (T_W)
  ) u_skew_b (
    .run_i      (run_active),
    .t_i        (t_q),
    .lane_en_o  (memb_read_enable),
    .lane_elem_o(memb_read_elem)
  );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer at N=4: a table of expected values for one
// reference pass, directed corner sequences, and a random run, all scored
// against a pass-progress reference model.
module tb_matmul_sequencer;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int RL = 3 * N - 2;
  localparam int NN = N * N;
  localparam int OW = 4 + 2 * (N + N * IW) + 2 * IW + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, result_ready;
  logic busy, done, array_clear, array_compute_enable, result_valid;
  logic [N-1:0]    mema_read_enable, memb_read_enable;
  logic [N*IW-1:0] mema_read_elem, memb_read_elem;
  logic [IW-1:0]   array_output_row, array_output_column;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: m_cyc = -1 when idle, otherwise cycles since the pass
  // began (0 = clear, 1..RL = run, RL+1 = result phase); m_ridx counts
  // accepted results, reaching NN for the done cycle.
  int m_cyc = -1;
  int m_ridx = 0;

  always #5 clk = ~clk;

  matmul_sequencer #(.ARRAY_DIM(N), .IDX_W(IW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .abort               (abort),
    .result_ready        (result_ready),
    .busy                (busy),
    .done                (done),
    .array_clear         (array_clear),
    .array_compute_enable(array_compute_enable),
    .mema_read_enable    (mema_read_enable),
    .mema_read_elem      (mema_read_elem),
    .memb_read_enable    (memb_read_enable),
    .memb_read_elem      (memb_read_elem),
    .array_output_row    (array_output_row),
    .array_output_column (array_output_column),
    .result_valid        (result_valid)
  );

  function automatic logic [OW-1:0] dut_vec();
    return {busy, done, array_clear, array_compute_enable,
            mema_read_enable, mema_read_elem, memb_read_enable, memb_read_elem,
            array_output_row, array_output_column, result_valid};
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    logic bz, dn, clr, cmp, val;
    logic [N-1:0] ea;
    logic [N*IW-1:0] ee;
    logic [IW-1:0] r, c;
    int t;
    bz  = (m_cyc >= 0);
    clr = (m_cyc == 0);
    cmp = (m_cyc >= 1 && m_cyc <= RL);
    val = (m_cyc == RL + 1 && m_ridx < NN);
    dn  = (m_cyc == RL + 1 && m_ridx == NN);
    ea  = '0;
    ee  = '0;
    if (cmp) begin
      t = m_cyc - 1;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) begin
          ea[i] = 1'b1;
          ee[i*IW +: IW] = IW'(t - i);
        end
      end
    end
    r = val ? IW'(m_ridx / N) : '0;
    c = val ? IW'(m_ridx % N) : '0;
    return {bz, dn, clr, cmp, ea, ee, ea, ee, r, c, val};
  endfunction

  task automatic model_step(input logic s, input logic a, input logic r);
    if (a) begin
      m_cyc = -1;
      m_ridx = 0;
    end else if (m_cyc < 0) begin
      if (s) m_cyc = 0;
    end else if (m_cyc <= RL) begin
      m_cyc++;
      m_ridx = 0;
    end else if (m_ridx < NN) begin
      if (r) m_ridx++;
    end else begin
      m_cyc = -1;
      m_ridx = 0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, score outputs mid-cycle, advance model.
  task automatic cyc(input logic s, input logic a, input logic r);
    start = s;
    abort = a;
    result_ready = r;
    @(negedge clk);
    check("model", 64'(dut_vec()), 64'(exp_vec()));
    @(posedge clk);
    model_step(s, a, r);
    #1;
  endtask

  task automatic chk_sel(input int r, input int c);
    check("select", {56'd0, array_output_row, array_output_column, result_valid},
          {56'd0, IW'(r), IW'(c), 1'b1});
  endtask

  typedef struct {
    int         cyc;
    logic       bz, clr, cmp, val, dn;
    logic [3:0] en;
    logic [7:0] elem;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00};
    tbl[2]  = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 8'h00};
    tbl[3]  = '{3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 8'h01};
    tbl[4]  = '{4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 8'h06};
    tbl[5]  = '{5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 8'h1B};
    tbl[6]  = '{6,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 8'h6C};
    tbl[7]  = '{7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 8'hB0};
    tbl[8]  = '{8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 8'hC0};
    tbl[9]  = '{9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00};
    tbl[10] = '{11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00};
    tbl[11] = '{12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 8'h00};
    tbl[12] = '{20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 8'h00};
    tbl[13] = '{27, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 8'h00};
    tbl[14] = '{28, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h00};
    tbl[15] = '{29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(dut_vec()), 64'd0);
    rst_n = 1'b1;

    // Reference pass: start for one cycle, consumer always ready.
    begin
      int valid_cnt;
      int first_valid;
      valid_cnt = 0;
      first_valid = -1;
      for (int c = 0; c < 31; c++) begin
        for (int k = 0; k < 16; k++) begin
          if (tbl[k].cyc == c) begin
            check($sformatf("table_cyc%0d", c),
                  64'({busy, array_clear, array_compute_enable, result_valid, done,
                       mema_read_enable, mema_read_elem, memb_read_enable, memb_read_elem}),
                  64'({tbl[k].bz, tbl[k].clr, tbl[k].cmp, tbl[k].val, tbl[k].dn,
                       tbl[k].en, tbl[k].elem, tbl[k].en, tbl[k].elem}));
          end
        end
        if (result_valid) begin
          valid_cnt++;
          if (first_valid < 0) first_valid = c;
        end
        cyc(c == 0, 1'b0, 1'b1);
      end
      check("valid_cycles", 64'(valid_cnt), 64'd16);
      check("first_valid_cycle", 64'(first_valid), 64'd12);
    end

    // Back-pressure at the start of READ: ready 1,0,0,1.
    cyc(1'b1, 1'b0, 1'b1);
    repeat (11) cyc(1'b0, 1'b0, 1'b1);
    chk_sel(0, 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk_sel(0, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk_sel(0, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk_sel(0, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk_sel(0, 2);
    repeat (18) cyc(1'b0, 1'b0, 1'b1);

    // Abort during RUN at t=5, then a clean pass.
    cyc(1'b1, 1'b0, 1'b1);
    repeat (6) cyc(1'b0, 1'b0, 1'b1);
    check("abort_at_t5_running", 64'({array_compute_enable, mema_read_enable}),
          64'({1'b1, 4'b1100}));
    cyc(1'b0, 1'b1, 1'b1);
    check("abort_idle", 64'({busy, done, mema_read_enable, memb_read_enable}), 64'd0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (32) cyc(1'b0, 1'b0, 1'b1);

    // start held high across several passes.
    repeat (70) cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);

    // Reset asserted during READ at (2,1).
    cyc(1'b1, 1'b0, 1'b1);
    repeat (11) cyc(1'b0, 1'b0, 1'b1);
    repeat (9) cyc(1'b0, 1'b0, 1'b1);
    chk_sel(2, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_read", 64'(dut_vec()), 64'd0);
    m_cyc = -1;
    m_ridx = 0;
    #1;
    rst_n = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (31) cyc(1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(3, 0) == 0, $urandom_range(39, 0) == 0, $urandom_range(1, 0) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
